// File: rtl/mod_updown_counter.sv
// mod_updown_counter
//   Up/down counter with a programmable modulus, synchronous clear and load,
//   and either wrap or saturate behaviour at the range boundaries. The count
//   always stays in 0..MODULO-1. A registered one-cycle wrap pulse and a
//   sticky saturation flag are provided for downstream control logic.
//
// Parameters
//   WIDTH    counter width in bits (>= 1)
//   MODULO   count range 0..MODULO-1, 2 <= MODULO <= 2**WIDTH
//   SATURATE 0 = wrap at the boundaries, 1 = hold at the boundaries
//
// Ports
//   clk      in  clock, all state changes on posedge
//   rst      in  synchronous active-high reset (highest priority)
//   clr      in  synchronous clear of count to 0
//   load     in  load load_val (clamped to MODULO-1)
//   load_val in  value to load
//   en       in  count enable
//   up       in  direction, 1 = increment, 0 = decrement
//   sat_clr  in  clears the sticky sat_flag
//   count    out registered count
//   at_max   out combinational, count == MODULO-1
//   at_zero  out combinational, count == 0
//   wrap     out registered pulse, count wrapped on the previous edge
//   sat_flag out sticky, a count step was blocked at a boundary

module mod_updown_counter #(
    parameter int WIDTH    = 8,
    parameter int MODULO   = 256,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic             sat_clr,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap,
    output logic             sat_flag
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO    = '0;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic             sat_set;

    // Priority: clr > load > en. rst is handled in the register process.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        sat_set = 1'b0;
        if (clr) begin
            count_d = ZERO;
        end else if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (up) begin
                if (count_q == MAX_VAL) begin
                    if (SATURATE) begin
                        sat_set = 1'b1;
                    end else begin
                        count_d = ZERO;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (count_q == ZERO) begin
                    if (SATURATE) begin
                        sat_set = 1'b1;
                    end else begin
                        count_d = MAX_VAL;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    // sat_clr applies regardless of clr/load; a simultaneous set wins.
    always_comb begin
        sat_d = sat_q;
        if (sat_clr) begin
            sat_d = 1'b0;
        end
        if (sat_set) begin
            sat_d = 1'b1;
        end
        if (!SATURATE) begin
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= ZERO;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign sat_flag = SATURATE ? sat_q : 1'b0;
    assign at_max   = (count_q == MAX_VAL);
    assign at_zero  = (count_q == ZERO);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: four instances share one input bus
//   0: WIDTH=3 MODULO=8  wrap      (natural overflow)
//   1: WIDTH=4 MODULO=10 wrap
//   2: WIDTH=4 MODULO=10 saturate
//   3: WIDTH=2 MODULO=2  wrap      (toggling case)
// A behavioural model tracks every instance; a vector table adds literal
// expectations for instances 1 and 2.

module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       sat_clr = 1'b0;

    logic [2:0] count_0;
    logic [3:0] count_1, count_2;
    logic [1:0] count_3;
    logic [3:0] at_max_v, at_zero_v, wrap_v, sat_v;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(3), .MODULO(8), .SATURATE(1'b0)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val[2:0]),
        .en(en), .up(up), .sat_clr(sat_clr), .count(count_0),
        .at_max(at_max_v[0]), .at_zero(at_zero_v[0]), .wrap(wrap_v[0]), .sat_flag(sat_v[0]));
    mod_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .sat_clr(sat_clr), .count(count_1),
        .at_max(at_max_v[1]), .at_zero(at_zero_v[1]), .wrap(wrap_v[1]), .sat_flag(sat_v[1]));
    mod_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .sat_clr(sat_clr), .count(count_2),
        .at_max(at_max_v[2]), .at_zero(at_zero_v[2]), .wrap(wrap_v[2]), .sat_flag(sat_v[2]));
    mod_updown_counter #(.WIDTH(2), .MODULO(2), .SATURATE(1'b0)) u3 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val[1:0]),
        .en(en), .up(up), .sat_clr(sat_clr), .count(count_3),
        .at_max(at_max_v[3]), .at_zero(at_zero_v[3]), .wrap(wrap_v[3]), .sat_flag(sat_v[3]));

    int n_vec  = 0;
    int n_fail = 0;

    int mods[4] = '{8, 10, 10, 2};
    int wids[4] = '{3, 4, 4, 2};
    bit sats[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    int m_cnt[4];
    bit m_wrap[4];
    bit m_sat[4];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_count(input int i);
        case (i)
            0: return int'(count_0);
            1: return int'(count_1);
            2: return int'(count_2);
            default: return int'(count_3);
        endcase
    endfunction

    // Range-based model: count lives in 0..mod-1; wrap = modular step crossed
    // a boundary; saturate = clamp with a blocked-step flag.
    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            int lv, nc, mx;
            bit nw, blk;
            mx  = mods[i] - 1;
            lv  = int'(load_val) % (1 << wids[i]);
            nc  = m_cnt[i];
            nw  = 1'b0;
            blk = 1'b0;
            if (rst) begin
                m_cnt[i] = 0; m_wrap[i] = 1'b0; m_sat[i] = 1'b0;
            end else begin
                if (clr) nc = 0;
                else if (load) nc = (lv > mx) ? mx : lv;
                else if (en && up) begin
                    if (sats[i]) begin
                        blk = (m_cnt[i] + 1 > mx);
                        nc  = blk ? mx : m_cnt[i] + 1;
                    end else begin
                        nw = (m_cnt[i] + 1 >= mods[i]);
                        nc = (m_cnt[i] + 1) % mods[i];
                    end
                end else if (en) begin
                    if (sats[i]) begin
                        blk = (m_cnt[i] - 1 < 0);
                        nc  = blk ? 0 : m_cnt[i] - 1;
                    end else begin
                        nw = (m_cnt[i] == 0);
                        nc = (m_cnt[i] - 1 + mods[i]) % mods[i];
                    end
                end
                m_cnt[i]  = nc;
                m_wrap[i] = nw;
                if (blk) m_sat[i] = 1'b1;
                else if (sat_clr) m_sat[i] = 1'b0;
                if (!sats[i]) m_sat[i] = 1'b0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s u%0d count", tag, i), dut_count(i), m_cnt[i]);
            chk($sformatf("%s u%0d wrap", tag, i), int'(wrap_v[i]), int'(m_wrap[i]));
            chk($sformatf("%s u%0d sat_flag", tag, i), int'(sat_v[i]), int'(m_sat[i]));
            chk($sformatf("%s u%0d at_max", tag, i), int'(at_max_v[i]), int'(m_cnt[i] == mods[i] - 1));
            chk($sformatf("%s u%0d at_zero", tag, i), int'(at_zero_v[i]), int'(m_cnt[i] == 0));
        end
    endtask

    // One clock edge: model advances on the edge, outputs sampled 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic drive(input bit r, input bit c, input bit l, input logic [3:0] lv,
                         input bit e, input bit u, input bit sc);
        rst = r; clr = c; load = l; load_val = lv; en = e; up = u; sat_clr = sc;
    endtask

    typedef struct {
        bit         rst, clr, load;
        logic [3:0] lv;
        bit         en, up, sat_clr;
        int         exp_cnt1;
        bit         exp_wrap1;
        int         exp_cnt2;
        bit         exp_sat2;
    } vec_t;

    vec_t vecs[24];

    initial begin
        // rst clr ld lv  en up sc | u1 cnt wrap | u2 cnt sat
        vecs[0]  = '{1,0,0,4'd0, 0,0,0, 0,0, 0,0};  // reset
        vecs[1]  = '{0,0,0,4'd0, 1,0,0, 9,1, 0,1};  // down from 0
        vecs[2]  = '{0,0,0,4'd0, 1,0,0, 8,0, 0,1};
        vecs[3]  = '{0,0,0,4'd0, 0,0,1, 8,0, 0,0};  // sat_clr, en=0
        vecs[4]  = '{0,0,1,4'd5, 0,0,0, 5,0, 5,0};  // load 5
        vecs[5]  = '{0,0,1,4'd13,0,0,0, 9,0, 9,0};  // load clamps
        vecs[6]  = '{0,0,1,4'd5, 1,1,0, 5,0, 5,0};  // load beats en
        vecs[7]  = '{0,0,0,4'd0, 1,1,0, 6,0, 6,0};
        vecs[8]  = '{0,0,0,4'd0, 1,1,0, 7,0, 7,0};
        vecs[9]  = '{0,0,0,4'd0, 1,1,0, 8,0, 8,0};
        vecs[10] = '{0,0,0,4'd0, 1,1,0, 9,0, 9,0};
        vecs[11] = '{0,0,0,4'd0, 1,1,0, 0,1, 9,1};  // upper boundary
        vecs[12] = '{0,0,0,4'd0, 1,1,1, 1,0, 9,1};  // set beats sat_clr
        vecs[13] = '{0,0,0,4'd0, 0,0,1, 1,0, 9,0};
        vecs[14] = '{1,1,1,4'd7, 1,1,0, 0,0, 0,0};  // rst beats everything
        vecs[15] = '{0,0,1,4'd6, 0,0,0, 6,0, 6,0};
        vecs[16] = '{0,1,1,4'd3, 1,1,0, 0,0, 0,0};  // clr beats load
        vecs[17] = '{0,0,0,4'd0, 1,1,0, 1,0, 1,0};
        vecs[18] = '{0,0,1,4'd6, 0,0,0, 6,0, 6,0};
        vecs[19] = '{1,0,0,4'd0, 1,1,0, 0,0, 0,0};  // reset mid-count
        vecs[20] = '{0,0,0,4'd0, 1,1,0, 1,0, 1,0};  // resumes from 0
        vecs[21] = '{0,0,0,4'd0, 1,0,0, 0,0, 0,0};
        vecs[22] = '{0,0,0,4'd0, 1,0,0, 9,1, 0,1};
        vecs[23] = '{0,1,0,4'd0, 0,0,0, 0,0, 0,1};  // clr keeps sat_flag

        // Reset state.
        drive(1, 0, 0, 4'd0, 0, 0, 0);
        tick("reset");

        // Table-driven vectors.
        for (int k = 0; k < 24; k++) begin
            drive(vecs[k].rst, vecs[k].clr, vecs[k].load, vecs[k].lv,
                  vecs[k].en, vecs[k].up, vecs[k].sat_clr);
            tick($sformatf("vec%0d", k));
            chk($sformatf("vec%0d tbl u1 count", k), int'(count_1), vecs[k].exp_cnt1);
            chk($sformatf("vec%0d tbl u1 wrap", k), int'(wrap_v[1]), int'(vecs[k].exp_wrap1));
            chk($sformatf("vec%0d tbl u2 count", k), int'(count_2), vecs[k].exp_cnt2);
            chk($sformatf("vec%0d tbl u2 sat", k), int'(sat_v[2]), int'(vecs[k].exp_sat2));
        end

        // Modulo-8 full cycle: 1..7,0 with wrap only after 7->0.
        drive(1, 0, 0, 4'd0, 0, 0, 0);
        tick("seq8 rst");
        drive(0, 0, 0, 4'd0, 1, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            tick($sformatf("seq8 e%0d", k));
            chk($sformatf("seq8 e%0d count", k), int'(count_0), k % 8);
            chk($sformatf("seq8 e%0d wrap", k), int'(wrap_v[0]), (k == 8) ? 1 : 0);
        end
        drive(0, 0, 0, 4'd0, 0, 0, 0);
        tick("seq8 hold");
        chk("seq8 wrap drops", int'(wrap_v[0]), 0);

        // Modulo-2 alternating direction: wraps on consecutive cycles.
        drive(1, 0, 0, 4'd0, 0, 0, 0);
        tick("mod2 rst");
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 4'd0, 1, k[0], 0);
            tick($sformatf("mod2 s%0d", k));
            chk($sformatf("mod2 s%0d wrap", k), int'(wrap_v[3]), 1);
        end

        // Randomized stimulus against the model.
        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0);
            tick($sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
